uart_baud_tick_gen: RTL and testbench

Runtime-programmable baud tick generator for the UART. It generates the oversample tick plus the mid-bit and bit-boundary strobes used by the UART RX and TX. The clock divisor is fractional, has an integer part and a fractional part, and can be reloaded at runtime without glitches. A resync input realigns the phase to an RX start edge.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/baud_divisor_shadow.sv | 114 +++++++++++
 rtl/uart_baud_tick_gen.sv | 146 ++++++++++++++
 tb/tb_uart_baud_tick_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: parameter defaults for the baud tick generator, the
// state encoding of the divisor load handshake, and the reset-default divisor
// rounding function (also used by testbenches to derive expected periods).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned CLOCK_RATE_DEF = 25000000;
   localparam int unsigned BAUD_RATE_DEF  = 9600;
   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned INT_BITS_DEF   = 16;
   localparam int unsigned FRAC_BITS_DEF  = 4;

   // Divisor load handshake: a validated divisor waits in the shadow register
   // until the next apply point.
   typedef enum logic [0:0] {
      LdIdle,
      LdPending
   } ld_state_e;

   // Fixed-point clocks per sample tick, rounded to nearest:
   //   round(clock_rate * 2^frac_bits / (baud_rate * oversample))
   // Upper bits are the integer part, low frac_bits bits the fraction.
   function automatic longint unsigned baud_def_div(
      input longint unsigned clock_rate,
      input longint unsigned baud_rate,
      input longint unsigned oversample,
      input longint unsigned frac_bits
   );
      longint unsigned num;
      longint unsigned den;
      num = clock_rate << frac_bits;
      den = baud_rate * oversample;
      return (num + (den >> 1)) / den;
   endfunction

endpackage

// File: rtl/baud_divisor_shadow.sv
// -----------------------------------------------------------------------------
// baud_divisor_shadow
// Runtime divisor reload handshake for the baud tick generator. A load request
// is validated (integer part must be >= 2), captured into a shadow register and
// held pending until the generator signals an apply point, at which time the
// shadow becomes the active divisor.
//
// Ports:
//   i_clock        clock
//   i_reset        synchronous active-high reset; restores the default divisor
//   i_div_int      requested integer divisor
//   i_div_frac     requested fractional divisor
//   i_div_load     one-cycle load request
//   i_apply_point  generator is at a point where a new divisor may be applied
//   o_act_int      active integer divisor
//   o_act_frac     active fractional divisor
//   o_div_ack      high in the cycle a pending divisor is applied
//   o_div_err      one-cycle pulse the cycle after a rejected load
// -----------------------------------------------------------------------------
module baud_divisor_shadow
   import uart_pkg::*;
#(
   parameter int unsigned          INT_BITS  = INT_BITS_DEF,
   parameter int unsigned          FRAC_BITS = FRAC_BITS_DEF,
   parameter logic [INT_BITS-1:0]  DEF_INT   = INT_BITS'(2),
   parameter logic [FRAC_BITS-1:0] DEF_FRAC  = '0
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [INT_BITS-1:0]  i_div_int,
   input  logic [FRAC_BITS-1:0] i_div_frac,
   input  logic                 i_div_load,
   input  logic                 i_apply_point,
   output logic [INT_BITS-1:0]  o_act_int,
   output logic [FRAC_BITS-1:0] o_act_frac,
   output logic                 o_div_ack,
   output logic                 o_div_err
);

   localparam logic [INT_BITS-1:0] MinInt = INT_BITS'(2);

   ld_state_e             state_q, state_d;
   logic [INT_BITS-1:0]   shadow_int_q, shadow_int_d;
   logic [FRAC_BITS-1:0]  shadow_frac_q, shadow_frac_d;
   logic [INT_BITS-1:0]   act_int_q, act_int_d;
   logic [FRAC_BITS-1:0]  act_frac_q, act_frac_d;
   logic                  err_q, err_d;
   logic                  load_ok;
   logic                  apply;

   // Divisors below 2 would allow back-to-back sample ticks.
   assign load_ok = i_div_load & (i_div_int >= MinInt);
   assign err_d   = i_div_load & (i_div_int < MinInt);

   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      unique case (state_q)
         LdIdle: begin
            if (load_ok) begin
               state_d = LdPending;
            end
         end
         LdPending: begin
            apply = i_apply_point;
            // A load coinciding with the apply refills the shadow and stays
            // pending for the following apply point.
            if (apply && !load_ok) begin
               state_d = LdIdle;
            end
         end
         default: state_d = LdIdle;
      endcase
   end

   always_comb begin
      shadow_int_d  = shadow_int_q;
      shadow_frac_d = shadow_frac_q;
      act_int_d     = act_int_q;
      act_frac_d    = act_frac_q;
      if (apply) begin
         act_int_d  = shadow_int_q;
         act_frac_d = shadow_frac_q;
      end
      if (load_ok) begin
         shadow_int_d  = i_div_int;
         shadow_frac_d = i_div_frac;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q       <= LdIdle;
         shadow_int_q  <= DEF_INT;
         shadow_frac_q <= DEF_FRAC;
         act_int_q     <= DEF_INT;
         act_frac_q    <= DEF_FRAC;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_int_q  <= shadow_int_d;
         shadow_frac_q <= shadow_frac_d;
         act_int_q     <= act_int_d;
         act_frac_q    <= act_frac_d;
         err_q         <= err_d;
      end
   end

   assign o_act_int  = act_int_q;
   assign o_act_frac = act_frac_q;
   assign o_div_ack  = apply & ~i_reset;
   assign o_div_err  = err_q & ~i_reset;

endmodule

// File: rtl/uart_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_tick_gen
// Fractional baud tick generator. A cycle counter runs to the active period
// P = div_int + carry, where carry comes from a FRAC_BITS accumulator that adds
// div_frac on every sample tick. A sample index counts ticks within a bit and
// decodes the mid-bit and bit-boundary strobes. The divisor is reloadable at
// runtime through baud_divisor_shadow; i_resync realigns the bit phase.
//
// Ports:
//   i_clock        clock
//   i_reset        synchronous active-high reset; forces all outputs low
//   i_enable       clock enable; when low, counter state holds, no strobes
//   i_div_int      integer clocks per sample tick (load value)
//   i_div_frac     fractional clocks per sample tick, units of 2^-FRAC_BITS
//   i_div_load     one-cycle divisor load request
//   o_div_ack      high in the cycle a loaded divisor takes effect
//   o_div_err      one-cycle pulse after a rejected load (div_int < 2)
//   i_resync       restart the bit phase; suppresses a coincident tick
//   o_sample_tick  oversample strobe
//   o_mid_tick     mid-bit strobe
//   o_bit_tick     bit-boundary strobe
// -----------------------------------------------------------------------------
module uart_baud_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = CLOCK_RATE_DEF,
   parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,  // power of two, >= 4
   parameter int unsigned INT_BITS   = INT_BITS_DEF,
   parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [INT_BITS-1:0]  i_div_int,
   input  logic [FRAC_BITS-1:0] i_div_frac,
   input  logic                 i_div_load,
   output logic                 o_div_ack,
   output logic                 o_div_err,
   input  logic                 i_resync,
   output logic                 o_sample_tick,
   output logic                 o_mid_tick,
   output logic                 o_bit_tick
);

   localparam int unsigned IDX_BITS = $clog2(OVERSAMPLE);

   localparam longint unsigned DefDiv = baud_def_div(64'(CLOCK_RATE), 64'(BAUD_RATE),
                                                     64'(OVERSAMPLE), 64'(FRAC_BITS));
   localparam logic [INT_BITS-1:0]  DefInt  = INT_BITS'(DefDiv >> FRAC_BITS);
   localparam logic [FRAC_BITS-1:0] DefFrac = FRAC_BITS'(DefDiv);

   localparam logic [IDX_BITS-1:0] MidIdx  = IDX_BITS'(OVERSAMPLE / 2 - 1);
   localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(OVERSAMPLE - 1);

   logic [INT_BITS-1:0]  cnt_q, cnt_d;
   logic [FRAC_BITS-1:0] acc_q, acc_d;
   logic                 carry_q, carry_d;
   logic [IDX_BITS-1:0]  idx_q, idx_d;

   logic [INT_BITS-1:0]  act_int;
   logic [FRAC_BITS-1:0] act_frac;
   logic [INT_BITS:0]    period_m1;
   logic [FRAC_BITS:0]   acc_sum;
   logic                 at_end;
   logic                 tick;
   logic                 apply_point;
   logic                 div_ack;

   // Divisor shadow / apply handshake.
   baud_divisor_shadow #(
      .INT_BITS  (INT_BITS),
      .FRAC_BITS (FRAC_BITS),
      .DEF_INT   (DefInt),
      .DEF_FRAC  (DefFrac)
   ) u_shadow (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_div_int     (i_div_int),
      .i_div_frac    (i_div_frac),
      .i_div_load    (i_div_load),
      .i_apply_point (apply_point),
      .o_act_int     (act_int),
      .o_act_frac    (act_frac),
      .o_div_ack     (div_ack),
      .o_div_err     (o_div_err)
   );

   // act_int >= 2 is guaranteed, so P - 1 never underflows.
   assign period_m1 = {1'b0, act_int} + {{INT_BITS{1'b0}}, carry_q}
                    - {{INT_BITS{1'b0}}, 1'b1};
   assign acc_sum   = {1'b0, acc_q} + {1'b0, act_frac};

   // '>=' rather than '==' so an apply that shortens the period while the
   // counter is held (enable low) still ends the period instead of wrapping.
   assign at_end = ({1'b0, cnt_q} >= period_m1);

   assign tick        = i_enable & ~i_resync & ~i_reset & at_end;
   assign apply_point = ~i_enable | i_resync | tick;

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      if (i_enable) begin
         if (i_resync) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            idx_d   = '0;
         end else if (tick) begin
            cnt_d            = '0;
            {carry_d, acc_d} = acc_sum;
            idx_d            = idx_q + IDX_BITS'(1);  // wraps at OVERSAMPLE
         end else begin
            cnt_d = cnt_q + INT_BITS'(1);
         end
      end
      // A newly applied divisor starts with a clean fractional phase.
      if (div_ack) begin
         acc_d   = '0;
         carry_d = 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   assign o_sample_tick = tick;
   assign o_mid_tick    = tick & (idx_q == MidIdx);
   assign o_bit_tick    = tick & (idx_q == LastIdx);
   assign o_div_ack     = div_ack;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_tick_gen
// Scoreboard bench: stimulus inserts expected strobe events (cycle + flags),
// the monitor compares every cycle with any output high against the queue,
// and flags missed or unexpected events. Outputs must be zero during reset.
// -----------------------------------------------------------------------------
module tb_uart_baud_tick_gen;

   localparam logic [4:0] FTick = 5'b00001;
   localparam logic [4:0] FMid  = 5'b00010;
   localparam logic [4:0] FBit  = 5'b00100;
   localparam logic [4:0] FErr  = 5'b01000;
   localparam logic [4:0] FAck  = 5'b10000;
   localparam logic [4:0] FNone = 5'b00000;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic [15:0] i_div_int;
   logic [3:0]  i_div_frac;
   logic        i_div_load;
   logic        i_resync;
   logic        o_div_ack;
   logic        o_div_err;
   logic        o_sample_tick;
   logic        o_mid_tick;
   logic        o_bit_tick;

   uart_baud_tick_gen dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_div_int     (i_div_int),
      .i_div_frac    (i_div_frac),
      .i_div_load    (i_div_load),
      .o_div_ack     (o_div_ack),
      .o_div_err     (o_div_err),
      .i_resync      (i_resync),
      .o_sample_tick (o_sample_tick),
      .o_mid_tick    (o_mid_tick),
      .o_bit_tick    (o_bit_tick)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      int unsigned cyc;
      logic [4:0]  flags;
   } ev_t;

   ev_t         exp_q[$];
   int unsigned cyc = 0;
   int unsigned base = 0;
   int          n_vec = 0;
   int          n_bad = 0;
   bit          flush = 1'b0;

   always @(posedge i_clock) cyc <= cyc + 1;

   // Sorted insert; events on the same cycle merge their flags.
   function automatic void expect_ev(input int unsigned t, input logic [4:0] f);
      int   i;
      ev_t  e;
      for (i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].cyc == t) begin
            exp_q[i].flags = exp_q[i].flags | f;
            return;
         end
         if (exp_q[i].cyc > t) break;
      end
      e.cyc   = t;
      e.flags = f;
      exp_q.insert(i, e);
   endfunction

   // Monitor: flags order is {ack, err, bit, mid, sample}.
   always @(negedge i_clock) begin
      logic [4:0] obs;
      obs = {o_div_ack, o_div_err, o_bit_tick, o_mid_tick, o_sample_tick};
      while (exp_q.size() > 0 && (exp_q[0].cyc < cyc || flush)) begin
         n_vec++;
         n_bad++;
         $display("FAIL missed_event cycle %0d: got no strobe, required flags %b",
                  exp_q[0].cyc - base, exp_q[0].flags);
         void'(exp_q.pop_front());
      end
      if (!flush) begin
         if (i_reset) begin
            n_vec++;
            if (obs !== FNone) begin
               n_bad++;
               $display("FAIL reset_outputs cycle %0d: got %b, required %b", cyc, obs, FNone);
            end
         end else if (obs != FNone) begin
            n_vec++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               n_bad++;
               $display("FAIL unexpected_strobe cycle %0d: got %b, required %b",
                        cyc - base, obs, FNone);
            end else begin
               if (exp_q[0].flags !== obs) begin
                  n_bad++;
                  $display("FAIL strobe_flags cycle %0d: got %b, required %b",
                           cyc - base, obs, exp_q[0].flags);
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   // Advance to relative cycle t (t measured from base).
   task automatic go(input int unsigned t);
      while (cyc < base + t) step();
   endtask

   // Default divisor 2604 = 162 + 12/16: periods 162,162,163,163,163,162,...
   int unsigned def_ticks[16] = '{161, 323, 486, 649, 812, 974, 1137, 1300,
                                  1463, 1625, 1788, 1951, 2114, 2276, 2439, 2602};

   initial begin
      i_reset    = 1'b1;
      i_enable   = 1'b0;
      i_div_int  = '0;
      i_div_frac = '0;
      i_div_load = 1'b0;
      i_resync   = 1'b0;
      repeat (4) step();

      // Cycle 0: first cycle out of reset with enable high.
      i_reset  = 1'b0;
      i_enable = 1'b1;
      base     = cyc;

      // Default divisor; 8th tick is mid-bit, 16th is bit boundary.
      for (int k = 0; k < 16; k++) begin
         expect_ev(base + def_ticks[k], FTick | ((k == 7) ? FMid : FNone)
                                             | ((k == 15) ? FBit : FNone));
      end

      // Mid-period load of 10: the 163-cycle period ends at 2765 with the ack,
      // then ticks every 10 cycles.
      expect_ev(base + 2765, FTick | FAck);
      for (int k = 1; k <= 4; k++) expect_ev(base + 2765 + 10 * k, FTick);
      go(2700);
      i_div_int  = 16'd10;
      i_div_frac = 4'd0;
      i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;

      // Rejected load of 1: error one cycle later, period stays 10, no ack.
      expect_ev(base + 2791, FErr);
      go(2790);
      i_div_int  = 16'd1;
      i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;

      // Resync on the terminal count at 2815: tick suppressed, idx restarts.
      for (int k = 0; k < 8; k++) begin
         expect_ev(base + 2825 + 10 * k, FTick | ((k == 7) ? FMid : FNone));
      end
      go(2815);
      i_resync = 1'b1;
      step();
      i_resync = 1'b0;

      // Enable low for 50 cycles at cnt=4: next tick slips from 2905 to 2955.
      for (int k = 0; k < 8; k++) begin
         expect_ev(base + 2955 + 10 * k, FTick | ((k == 7) ? FBit : FNone));
      end
      go(2900);
      i_enable = 1'b0;
      go(2950);
      i_enable = 1'b1;

      // Pending load of 12 is acked on the first disabled cycle.
      expect_ev(base + 3031, FAck);
      expect_ev(base + 3042, FTick);
      expect_ev(base + 3054, FTick);
      go(3030);
      i_div_int  = 16'd12;
      i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      i_enable   = 1'b0;
      go(3036);
      i_enable = 1'b1;

      // Reset with a load of 20 pending: no ack, default divisor restored.
      expect_ev(base + 3225, FTick);
      expect_ev(base + 3387, FTick);
      go(3060);
      i_div_int  = 16'd20;
      i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      i_reset    = 1'b1;
      go(3064);
      i_reset = 1'b0;

      // Minimum divisor 2, applied by a resync: ack on the resync cycle.
      expect_ev(base + 3391, FAck);
      expect_ev(base + 3393, FTick);
      expect_ev(base + 3395, FTick);
      expect_ev(base + 3397, FTick);
      go(3390);
      i_div_int  = 16'd2;
      i_div_frac = 4'd0;
      i_div_load = 1'b1;
      step();
      i_div_load = 1'b0;
      i_resync   = 1'b1;
      step();
      i_resync = 1'b0;
      go(3398);
      i_enable = 1'b0;
      go(3420);

      flush = 1'b1;
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
